// File: rtl/filter_pkg.sv
// Shared types and sizing for the convolution filter store write side.
package filter_pkg;

    localparam int WIDTH     = 8;
    localparam int K         = 3;
    localparam int C         = 3;
    localparam int N_FILTERS = 4;
    localparam int IDX_W     = 2;

    localparam logic [IDX_W-1:0] ROW_MAX  = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] COL_MAX  = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] CHAN_MAX = IDX_W'(C - 1);

    // Indexed [row][col][channel]; each element is one signed weight.
    typedef logic signed [K-1:0][K-1:0][C-1:0][WIDTH-1:0] filter_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/filter_addr_counter.sv
// Nested column/row/channel write address for one 3x3x3 bank.
// Wraps back to (0,0,0) after the last element so load_all chains banks without a gap.
module filter_addr_counter
    import filter_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_row,
    output logic [IDX_W-1:0] o_col,
    output logic [IDX_W-1:0] o_chan,
    output logic             o_last
);

    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;
    logic [IDX_W-1:0] r_chan;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_row  <= '0;
            r_col  <= '0;
            r_chan <= '0;
        end else if (i_inc) begin
            if (r_col == COL_MAX) begin
                r_col <= '0;
                if (r_row == ROW_MAX) begin
                    r_row  <= '0;
                    r_chan <= (r_chan == CHAN_MAX) ? '0 : r_chan + 2'd1;
                end else begin
                    r_row <= r_row + 2'd1;
                end
            end else begin
                r_col <= r_col + 2'd1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_chan = r_chan;
    assign o_last = (r_row == ROW_MAX) && (r_col == COL_MAX) && (r_chan == CHAN_MAX);

endmodule

// File: rtl/filter_loader.sv
// Streams signed weights into four 3x3x3 filter banks, one bank or all four in turn.
//   state | meaning
//   IDLE  | waiting for start; w_ready low
//   LOAD  | accepting words into the current bank
//   DONE  | one-cycle completion pulse, then back to IDLE
module filter_loader
    import filter_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_load_all,
    input  logic [1:0]           i_load_sel,
    input  logic                 i_w_valid,
    input  logic [WIDTH-1:0]     i_w_data,
    output logic                 o_w_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [N_FILTERS-1:0] o_bank_valid,
    output filter_t              o_filtro1,
    output filter_t              o_filtro2,
    output filter_t              o_filtro3,
    output filter_t              o_filtro4
);

    ld_state_t            r_state;
    ld_state_t            w_state_nxt;
    logic                 r_all;
    logic [1:0]           r_bank;
    logic [N_FILTERS-1:0] r_bank_valid;
    filter_t              r_filt [N_FILTERS];

    logic [IDX_W-1:0]     w_row;
    logic [IDX_W-1:0]     w_col;
    logic [IDX_W-1:0]     w_chan;
    logic                 w_last;
    logic                 w_ready;
    logic                 w_launch;
    logic                 w_accept;
    logic                 w_load_end;
    logic [N_FILTERS-1:0] w_clr_mask;

    assign w_ready    = (r_state == LOAD);
    assign w_launch   = (r_state == IDLE) && i_start;
    assign w_accept   = w_ready && i_w_valid;
    assign w_load_end = w_accept && w_last && (!r_all || (r_bank == 2'd3));
    assign w_clr_mask = i_load_all ? {N_FILTERS{1'b1}} : (4'b0001 << i_load_sel);

    filter_addr_counter u_addr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_launch),
        .i_inc   (w_accept),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_chan  (w_chan),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = LOAD;
            LOAD:    if (w_load_end) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Launch and accept are mutually exclusive (IDLE vs LOAD), so both may touch r_bank_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_all        <= 1'b0;
            r_bank       <= '0;
            r_bank_valid <= '0;
            for (int n = 0; n < N_FILTERS; n++) r_filt[n] <= '0;
        end else begin
            if (w_launch) begin
                r_all        <= i_load_all;
                r_bank       <= i_load_all ? 2'd0 : i_load_sel;
                r_bank_valid <= r_bank_valid & ~w_clr_mask;
            end
            if (w_accept) begin
                r_filt[r_bank][w_row][w_col][w_chan] <= i_w_data;
                if (w_last) begin
                    r_bank_valid[r_bank] <= 1'b1;
                    if (r_all && (r_bank != 2'd3)) r_bank <= r_bank + 2'd1;
                end
            end
        end
    end

    assign o_w_ready    = w_ready;
    assign o_busy       = (r_state != IDLE);
    assign o_done       = (r_state == DONE);
    assign o_bank_valid = r_bank_valid;
    assign o_filtro1    = r_filt[0];
    assign o_filtro2    = r_filt[1];
    assign o_filtro3    = r_filt[2];
    assign o_filtro4    = r_filt[3];

endmodule

// File: tb/tb_filter_loader.sv
// Self-checking bench for filter_loader: directed load sequences plus a table of random loads.
module tb_filter_loader;
    import filter_pkg::*;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic             i_load_all;
    logic [1:0]       i_load_sel;
    logic             i_w_valid;
    logic [WIDTH-1:0] i_w_data;
    logic             o_w_ready;
    logic             o_busy;
    logic             o_done;
    logic [3:0]       o_bank_valid;
    filter_t          o_filtro1, o_filtro2, o_filtro3, o_filtro4;

    filter_loader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_load_all   (i_load_all),
        .i_load_sel   (i_load_sel),
        .i_w_valid    (i_w_valid),
        .i_w_data     (i_w_data),
        .o_w_ready    (o_w_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_bank_valid (o_bank_valid),
        .o_filtro1    (o_filtro1),
        .o_filtro2    (o_filtro2),
        .o_filtro3    (o_filtro3),
        .o_filtro4    (o_filtro4)
    );

    always #5 i_clk = ~i_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_w [4][27];   // reference contents by stream position n = 9k + 3i + j
    logic [3:0] m_valid;
    int         words [108];

    typedef struct {
        bit         all;
        logic [1:0] sel;
        int         gap_pct;
        logic [3:0] exp_valid;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int elem(input int b, input int i, input int j, input int k);
        filter_t f;
        case (b)
            0:       f = o_filtro1;
            1:       f = o_filtro2;
            2:       f = o_filtro3;
            default: f = o_filtro4;
        endcase
        return int'($signed(f[i][j][k]));
    endfunction

    function automatic int filt_mismatches();
        int m = 0;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (elem(b, i, j, k) != m_w[b][9*k + 3*i + j]) m++;
        return m;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int n = 0; n < 27; n++) m_w[b][n] = 0;
        m_valid = 4'b0000;
    endtask

    task automatic apply_reset(input bit with_start);
        i_rst      = 1'b1;
        i_start    = with_start;
        i_load_all = 1'b1;
        i_w_valid  = 1'b0;
        step();
        i_rst   = 1'b0;
        i_start = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " filters zero"}, filt_mismatches(), 0);
        check({tag, " bank_valid"}, o_bank_valid, 0);
        check({tag, " w_ready"}, o_w_ready, 0);
        check({tag, " busy"}, o_busy, 0);
        check({tag, " done"}, o_done, 0);
    endtask

    task automatic fill_random();
        for (int n = 0; n < 108; n++) words[n] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Runs one load; stops early after stop_at accepted words (for the reset-abort case).
    task automatic do_load(input bit all, input logic [1:0] sel, input int gap_pct,
                           input int glitch_at, input int stop_at, input string tag);
        int nw     = all ? 108 : 27;
        int target = (stop_at < nw) ? stop_at : nw;
        int acc    = 0;
        int cycles = 0;
        int dones  = 0;
        int vmis   = 0;
        int fmis   = 0;
        int bidx;
        bit v, take;
        i_start    = 1'b1;
        i_load_all = all;
        i_load_sel = sel;
        step();
        i_start = 1'b0;
        if (all) m_valid = 4'b0000;
        else     m_valid[sel] = 1'b0;
        check({tag, " busy on start"}, o_busy, 1);
        check({tag, " bank_valid on start"}, o_bank_valid, m_valid);
        while (acc < target && cycles < 4000) begin
            if (acc == glitch_at) begin
                i_start    = 1'b1;
                i_load_all = ~all;
                i_load_sel = sel + 2'd1;
            end
            v         = ($urandom_range(0, 99) >= gap_pct);
            i_w_valid = v;
            i_w_data  = v ? WIDTH'(words[acc]) : WIDTH'($urandom);
            take      = v && o_w_ready;
            step();
            i_start = 1'b0;
            cycles++;
            if (take) begin
                bidx = all ? acc / 27 : int'(sel);
                m_w[bidx][acc % 27] = words[acc];
                if (acc % 27 == 26) m_valid[bidx] = 1'b1;
                acc++;
            end
            if (o_done) dones++;
            if (o_bank_valid != m_valid) vmis++;
            fmis += filt_mismatches();
        end
        i_w_valid = 1'b0;
        check({tag, " words accepted"}, acc, target);
        check({tag, " bank_valid track"}, vmis, 0);
        check({tag, " filters track"}, fmis, 0);
        if (stop_at >= nw) begin
            check({tag, " done after last word"}, o_done, 1);
            check({tag, " done count"}, dones, 1);
            step();
            check({tag, " done dropped"}, o_done, 0);
            check({tag, " idle after done"}, o_busy, 0);
        end
    endtask

    initial begin
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_load_all = 1'b0;
        i_load_sel = 2'd0;
        i_w_valid  = 1'b0;
        i_w_data   = '0;
        vecs[0] = '{all: 1'b0, sel: 2'd3, gap_pct: 30, exp_valid: 4'b1010};
        vecs[1] = '{all: 1'b0, sel: 2'd0, gap_pct: 50, exp_valid: 4'b1011};
        vecs[2] = '{all: 1'b1, sel: 2'd2, gap_pct: 20, exp_valid: 4'b1111};
        vecs[3] = '{all: 1'b0, sel: 2'd2, gap_pct: 0,  exp_valid: 4'b1111};

        apply_reset(1'b1);
        check_reset_state("reset");

        for (int n = 0; n < 108; n++) words[n] = n + 1;
        do_load(1'b0, 2'd2, 0, -1, 999, "sel2");
        check("sel2 F3[0][0][0]", elem(2, 0, 0, 0), 1);
        check("sel2 F3[2][2][0]", elem(2, 2, 2, 0), 9);
        check("sel2 F3[0][0][1]", elem(2, 0, 0, 1), 10);
        check("sel2 F3[2][2][2]", elem(2, 2, 2, 2), 27);
        check("sel2 bank_valid", o_bank_valid, 4'b0100);

        for (int n = 0; n < 108; n++) words[n] = -(n + 1);
        do_load(1'b1, 2'd0, 40, -1, 999, "all");
        check("all F1[0][0][0]", elem(0, 0, 0, 0), -1);
        check("all F4[2][2][2]", elem(3, 2, 2, 2), -108);
        check("all bank_valid", o_bank_valid, 4'b1111);

        fill_random();
        do_load(1'b0, 2'd0, 25, 10, 999, "reload0");
        check("reload0 bank_valid", o_bank_valid, 4'b1111);

        fill_random();
        do_load(1'b0, 2'd1, 20, -1, 13, "abort");
        apply_reset(1'b0);
        check_reset_state("abort reset");
        fill_random();
        do_load(1'b0, 2'd1, 10, -1, 999, "fresh1");
        check("fresh1 bank_valid", o_bank_valid, 4'b0010);

        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 3; c++) begin
                i_w_valid = 1'b1;
                i_w_data  = WIDTH'($urandom);
                step();
            end
            i_w_valid = 1'b0;
            check($sformatf("vec%0d idle writes ignored", t), filt_mismatches(), 0);
            fill_random();
            do_load(vecs[t].all, vecs[t].sel, vecs[t].gap_pct, -1, 999, $sformatf("vec%0d", t));
            check($sformatf("vec%0d bank_valid", t), o_bank_valid, vecs[t].exp_valid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
